// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst/response encodings, slave FSM states
// and burst geometry helpers.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Undefined-length INCR reports 0 beats.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_SINGLE:               burst_beats = 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                     burst_beats = 5'd0;
        endcase
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst[0] == 1'b0) && (burst != HBURST_SINGLE);
    endfunction

    function automatic logic [11:0] wrap_mask(input logic [2:0] burst, input logic [2:0] size);
        return ({7'd0, burst_beats(burst)} << size) - 12'd1;
    endfunction

endpackage

// File: rtl/ahb_slave_burst_chk.sv
// Tracks the beat counter and previous address of the current burst and
// flags whether the SEQ address phase on the bus continues it correctly.
module ahb_slave_burst_chk
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rstn_in,
    input  logic                      take,
    input  logic                      clear,
    input  logic [1:0]                trans,
    input  logic [2:0]                burst,
    input  logic [2:0]                size,
    input  logic [AHB_ADDR_WIDTH-1:0] addr,
    output logic                      seq_ok
);

    localparam int AW = AHB_ADDR_WIDTH;

    logic          active_reg;
    logic [3:0]    beat_cnt_reg;
    logic [AW-1:0] prev_addr_reg;
    logic [2:0]    prev_size_reg;
    logic [2:0]    prev_burst_reg;

    logic [AW-1:0] incr;
    logic [AW-1:0] lin_next;
    logic [AW-1:0] wrap_m;
    logic [AW-1:0] exp_addr;
    logic [4:0]    beats;

    assign beats    = burst_beats(burst);
    assign incr     = AW'(1) << prev_size_reg;
    assign lin_next = prev_addr_reg + incr;
    assign wrap_m   = AW'(wrap_mask(prev_burst_reg, prev_size_reg));
    assign exp_addr = burst_is_wrap(prev_burst_reg)
                    ? ((prev_addr_reg & ~wrap_m) | (lin_next & wrap_m))
                    : lin_next;

    // Fixed-length bursts run out of beats at 0; INCR never does.
    always_comb begin
        seq_ok = 1'b1;
        if (trans == HTRANS_SEQ) begin
            seq_ok = active_reg
                  && (burst == prev_burst_reg)
                  && (size == prev_size_reg)
                  && (addr == exp_addr)
                  && !((prev_burst_reg != HBURST_INCR) && (beat_cnt_reg == 4'd0));
        end
    end

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            active_reg     <= 1'b0;
            beat_cnt_reg   <= 4'd0;
            prev_addr_reg  <= '0;
            prev_size_reg  <= 3'd0;
            prev_burst_reg <= 3'd0;
        end else if (clear) begin
            active_reg   <= 1'b0;
            beat_cnt_reg <= 4'd0;
        end else if (take) begin
            prev_addr_reg <= addr;
            if (trans == HTRANS_NONSEQ) begin
                active_reg     <= 1'b1;
                prev_size_reg  <= size;
                prev_burst_reg <= burst;
                beat_cnt_reg   <= (beats == 5'd0) ? 4'd0 : 4'(beats - 5'd1);
            end else if (beat_cnt_reg != 4'd0) begin
                beat_cnt_reg <= beat_cnt_reg - 4'd1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end: validates address phases, forwards accepted transfers
// to a valid/ready backend and generates wait states and two-cycle ERRORs.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int WAIT_TIMEOUT   = 16
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rstn_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic [2:0]                ahb_burst_in,
    input  logic [2:0]                ahb_size_in,
    input  logic                      ahb_write_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    input  logic                      ahb_ready_in,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
    output logic                      other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
    output logic                      other_write_out,
    output logic [2:0]                other_size_out,
    output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
    input  logic                      other_ready_in,
    input  logic                      other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

    localparam int MAX_SIZE = $clog2(AHB_DATA_WIDTH / 8);
    localparam int WCW      = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = (WAIT_TIMEOUT > 0) ? WCW'(WAIT_TIMEOUT - 1) : '0;

    slave_state_e              state_reg;
    logic [WCW-1:0]            wait_cnt_reg;
    logic [AHB_ADDR_WIDTH-1:0] addr_reg;
    logic                      write_reg;
    logic [2:0]                size_reg;
    logic [AHB_DATA_WIDTH-1:0] rdata_reg;

    logic       accept, size_ok, align_ok, seq_ok, phase_ok;
    logic       data_done, timeout_hit, addr_slot, take, go_err;
    logic [7:0] low_mask;

    assign accept    = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
    assign size_ok   = (ahb_size_in <= 3'(MAX_SIZE));
    assign low_mask  = (8'd1 << ahb_size_in) - 8'd1;
    assign align_ok  = ((ahb_addr_in[7:0] & low_mask) == 8'd0);
    assign phase_ok  = size_ok & align_ok & seq_ok;

    assign data_done   = (state_reg == ST_ACCESS) & other_ready_in;
    assign timeout_hit = (WAIT_TIMEOUT != 0) && (state_reg == ST_ACCESS) && !other_ready_in
                      && (wait_cnt_reg == WAIT_LAST);
    // A new address phase can only be taken while the bus sees us ready.
    assign addr_slot = (state_reg == ST_IDLE) || (state_reg == ST_ERR2)
                    || (data_done && !other_error_in);
    assign take      = addr_slot & accept;
    assign go_err    = (take & ~phase_ok) | (data_done & other_error_in) | timeout_hit;

    ahb_slave_burst_chk #(
        .AHB_ADDR_WIDTH(AHB_ADDR_WIDTH)
    ) u_burst_chk (
        .ahb_clk_in (ahb_clk_in),
        .ahb_rstn_in(ahb_rstn_in),
        .take       (take & phase_ok),
        .clear      (go_err),
        .trans      (ahb_trans_in),
        .burst      (ahb_burst_in),
        .size       (ahb_size_in),
        .addr       (ahb_addr_in),
        .seq_ok     (seq_ok)
    );

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            size_reg     <= 3'd0;
            rdata_reg    <= '0;
        end else begin
            wait_cnt_reg <= '0;
            if (take) begin
                addr_reg  <= ahb_addr_in;
                write_reg <= ahb_write_in;
                size_reg  <= ahb_size_in;
            end
            case (state_reg)
                ST_IDLE, ST_ERR2: begin
                    if (take) state_reg <= phase_ok ? ST_ACCESS : ST_ERR1;
                    else      state_reg <= ST_IDLE;
                end
                ST_ACCESS: begin
                    if (other_ready_in) begin
                        if (other_error_in) begin
                            state_reg <= ST_ERR1;
                        end else begin
                            rdata_reg <= write_reg ? '0 : other_rdata_in;
                            if (take) state_reg <= phase_ok ? ST_ACCESS : ST_ERR1;
                            else      state_reg <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= ST_ERR1;
                    end else if (WAIT_TIMEOUT != 0) begin
                        wait_cnt_reg <= wait_cnt_reg + WCW'(1);
                    end
                end
                ST_ERR1: state_reg <= ST_ERR2;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ahb_readyout_out = 1'b1;
        ahb_resp_out     = HRESP_OKAY;
        case (state_reg)
            ST_ACCESS: ahb_readyout_out = other_ready_in & ~other_error_in;
            ST_ERR1: begin
                ahb_readyout_out = 1'b0;
                ahb_resp_out     = HRESP_ERROR;
            end
            ST_ERR2: ahb_resp_out = HRESP_ERROR;
            default: ;
        endcase
    end

    // Read data bypasses the register in the completing cycle and is held after.
    assign ahb_rdata_out   = (data_done && !other_error_in && !write_reg) ? other_rdata_in : rdata_reg;
    assign other_valid_out = (state_reg == ST_ACCESS);
    assign other_addr_out  = addr_reg;
    assign other_write_out = write_reg;
    assign other_size_out  = size_reg;
    assign other_wdata_out = (state_reg == ST_ACCESS) ? ahb_wdata_in : '0;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: single transfers, wait states, alignment,
// wrap-burst continuity, backend timeout and mid-transfer reset.
module tb_ahb_slave_if;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          sel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic [2:0]    hsize;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          readyout;
    logic          resp;
    logic [DW-1:0] rdata;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic          o_write;
    logic [2:0]    o_size;
    logic [DW-1:0] o_wdata;
    logic          b_ready;
    logic          b_error;
    logic [DW-1:0] b_rdata;

    int checks = 0;
    int errors = 0;
    int waits;

    always #5 clk = ~clk;

    // Single slave on the bus: HREADY is our own HREADYOUT.
    assign hready = readyout;

    ahb_slave_if #(
        .AHB_ADDR_WIDTH(AW),
        .AHB_DATA_WIDTH(DW),
        .WAIT_TIMEOUT  (16)
    ) dut (
        .ahb_clk_in      (clk),
        .ahb_rstn_in     (rstn),
        .ahb_sel_in      (sel),
        .ahb_addr_in     (haddr),
        .ahb_trans_in    (htrans),
        .ahb_burst_in    (hburst),
        .ahb_size_in     (hsize),
        .ahb_write_in    (hwrite),
        .ahb_wdata_in    (hwdata),
        .ahb_ready_in    (hready),
        .ahb_readyout_out(readyout),
        .ahb_resp_out    (resp),
        .ahb_rdata_out   (rdata),
        .other_valid_out (o_valid),
        .other_addr_out  (o_addr),
        .other_write_out (o_write),
        .other_size_out  (o_size),
        .other_wdata_out (o_wdata),
        .other_ready_in  (b_ready),
        .other_error_in  (b_error),
        .other_rdata_in  (b_rdata)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        sel    = 1'b0;
        htrans = HTRANS_IDLE;
        haddr  = '0;
        hburst = HBURST_SINGLE;
        hsize  = 3'd2;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic [1:0] t, input logic [AW-1:0] a,
                              input logic [2:0] b, input logic [2:0] s, input logic w);
        sel    = 1'b1;
        htrans = t;
        haddr  = a;
        hburst = b;
        hsize  = s;
        hwrite = w;
    endtask

    task automatic to_next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string name);
        $display("txn %-16s t=%0t", name, $time);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_idle();
        hwdata  = '0;
        b_ready = 1'b0;
        b_error = 1'b0;
        b_rdata = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_readyout", readyout, 1);
        check_val("rst_resp",     resp,     0);
        check_val("rst_rdata",    rdata,    0);
        check_val("rst_valid",    o_valid,  0);
        check_val("rst_oaddr",    o_addr,   0);
        txn("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Zero-wait single write
        addr_phase(HTRANS_NONSEQ, 32'h100, HBURST_SINGLE, 3'd2, 1'b1);
        @(negedge clk);
        check_val("t1_aphase_ready", readyout, 1);
        check_val("t1_aphase_valid", o_valid,  0);
        to_next_cycle();
        bus_idle();
        hwdata  = 32'hCAFE0001;
        b_ready = 1'b1;
        @(negedge clk);
        check_val("t1_valid",    o_valid,  1);
        check_val("t1_oaddr",    o_addr,   32'h100);
        check_val("t1_owrite",   o_write,  1);
        check_val("t1_osize",    o_size,   2);
        check_val("t1_owdata",   o_wdata,  32'hCAFE0001);
        check_val("t1_readyout", readyout, 1);
        check_val("t1_resp",     resp,     0);
        to_next_cycle();
        b_ready = 1'b0;
        @(negedge clk);
        check_val("t1_valid_drop", o_valid, 0);
        txn("write 0x100");

        // Read with three wait states
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h20, HBURST_SINGLE, 3'd2, 1'b0);
        @(negedge clk);
        to_next_cycle();
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t2_wait_readyout", readyout, 0);
            check_val("t2_wait_valid",    o_valid,  1);
            to_next_cycle();
        end
        b_ready = 1'b1;
        b_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check_val("t2_readyout", readyout, 1);
        check_val("t2_resp",     resp,     0);
        check_val("t2_rdata",    rdata,    32'hDEADBEEF);
        check_val("t2_owrite",   o_write,  0);
        to_next_cycle();
        b_ready = 1'b0;
        b_rdata = '0;
        @(negedge clk);
        check_val("t2_rdata_held", rdata,   32'hDEADBEEF);
        check_val("t2_valid_drop", o_valid, 0);
        txn("read 0x20");

        // Unaligned word access
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h102, HBURST_SINGLE, 3'd2, 1'b1);
        @(negedge clk);
        to_next_cycle();
        bus_idle();
        @(negedge clk);
        check_val("t3_err1_valid",    o_valid,  0);
        check_val("t3_err1_readyout", readyout, 0);
        check_val("t3_err1_resp",     resp,     1);
        to_next_cycle();
        @(negedge clk);
        check_val("t3_err2_readyout", readyout, 1);
        check_val("t3_err2_resp",     resp,     1);
        to_next_cycle();
        @(negedge clk);
        check_val("t3_idle_resp", resp,    0);
        check_val("t3_idle_valid", o_valid, 0);
        txn("unaligned 0x102");

        // WRAP4 0x38,0x3C,(BUSY),0x30,0x34
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h38, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h3C, HBURST_WRAP4, 3'd2, 1'b1);
        b_ready = 1'b1;
        @(negedge clk);
        check_val("t4_b0_oaddr", o_addr,   32'h38);
        check_val("t4_b0_ready", readyout, 1);
        check_val("t4_b0_resp",  resp,     0);
        to_next_cycle();
        addr_phase(HTRANS_BUSY, 32'h30, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        check_val("t4_b1_oaddr", o_addr, 32'h3C);
        check_val("t4_b1_resp",  resp,   0);
        to_next_cycle();
        b_ready = 1'b0;
        @(negedge clk);
        check_val("t4_busy_valid", o_valid,  0);
        check_val("t4_busy_ready", readyout, 1);
        check_val("t4_busy_resp",  resp,     0);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h30, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h34, HBURST_WRAP4, 3'd2, 1'b1);
        b_ready = 1'b1;
        @(negedge clk);
        check_val("t4_b2_valid", o_valid, 1);
        check_val("t4_b2_oaddr", o_addr,  32'h30);
        check_val("t4_b2_resp",  resp,    0);
        to_next_cycle();
        bus_idle();
        @(negedge clk);
        check_val("t4_b3_oaddr", o_addr, 32'h34);
        check_val("t4_b3_resp",  resp,   0);
        to_next_cycle();
        b_ready = 1'b0;
        @(negedge clk);
        check_val("t4_end_valid", o_valid, 0);
        txn("wrap4 0x38");

        // WRAP4 with a broken second SEQ (0x40)
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h38, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h3C, HBURST_WRAP4, 3'd2, 1'b1);
        b_ready = 1'b1;
        @(negedge clk);
        check_val("t5_b0_resp", resp, 0);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h40, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        check_val("t5_b1_oaddr", o_addr,   32'h3C);
        check_val("t5_b1_ready", readyout, 1);
        check_val("t5_b1_resp",  resp,     0);
        to_next_cycle();
        bus_idle();
        b_ready = 1'b0;
        @(negedge clk);
        check_val("t5_err1_ready", readyout, 0);
        check_val("t5_err1_resp",  resp,     1);
        check_val("t5_err1_valid", o_valid,  0);
        to_next_cycle();
        addr_phase(HTRANS_SEQ, 32'h44, HBURST_WRAP4, 3'd2, 1'b1);
        @(negedge clk);
        check_val("t5_err2_ready", readyout, 1);
        check_val("t5_err2_resp",  resp,     1);
        to_next_cycle();
        bus_idle();
        @(negedge clk);
        check_val("t5_orphan_seq_ready", readyout, 0);
        check_val("t5_orphan_seq_resp",  resp,     1);
        check_val("t5_orphan_seq_valid", o_valid,  0);
        to_next_cycle();
        @(negedge clk);
        to_next_cycle();
        @(negedge clk);
        check_val("t5_recover_resp", resp, 0);
        txn("wrap4 bad seq");

        // Backend never ready
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h200, HBURST_SINGLE, 3'd2, 1'b0);
        @(negedge clk);
        to_next_cycle();
        bus_idle();
        waits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid && !readyout) waits++;
            else break;
            to_next_cycle();
        end
        check_val("t6_wait_cycles", waits,    16);
        check_val("t6_err1_ready",  readyout, 0);
        check_val("t6_err1_resp",   resp,     1);
        check_val("t6_err1_valid",  o_valid,  0);
        to_next_cycle();
        @(negedge clk);
        check_val("t6_err2_ready", readyout, 1);
        check_val("t6_err2_resp",  resp,     1);
        txn("timeout 0x200");

        // Reset during an ACCESS wait
        to_next_cycle();
        addr_phase(HTRANS_NONSEQ, 32'h300, HBURST_SINGLE, 3'd2, 1'b1);
        @(negedge clk);
        to_next_cycle();
        bus_idle();
        @(negedge clk);
        check_val("t7_pre_valid", o_valid,  1);
        check_val("t7_pre_ready", readyout, 0);
        #1 rstn = 1'b0;
        #1;
        check_val("t7_rst_valid",  o_valid,  0);
        check_val("t7_rst_ready",  readyout, 1);
        check_val("t7_rst_resp",   resp,     0);
        check_val("t7_rst_oaddr",  o_addr,   0);
        check_val("t7_rst_owrite", o_write,  0);
        check_val("t7_rst_osize",  o_size,   0);
        @(posedge clk);
        #1 rstn = 1'b1;
        addr_phase(HTRANS_NONSEQ, 32'h44, HBURST_SINGLE, 3'd2, 1'b0);
        @(negedge clk);
        check_val("t7_post_aphase_ready", readyout, 1);
        to_next_cycle();
        bus_idle();
        b_ready = 1'b1;
        b_rdata = 32'h12345678;
        @(negedge clk);
        check_val("t7_post_valid", o_valid,  1);
        check_val("t7_post_oaddr", o_addr,   32'h44);
        check_val("t7_post_ready", readyout, 1);
        check_val("t7_post_resp",  resp,     0);
        check_val("t7_post_rdata", rdata,    32'h12345678);
        to_next_cycle();
        b_ready = 1'b0;
        @(negedge clk);
        check_val("t7_post_valid_drop", o_valid, 0);
        txn("reset mid-access");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
